// File: rtl/rv32i_instr_encoder_if.sv
// Descriptor-in / machine-word-out handshake bundle for the RV32I encoder.
// The slave modport is the encoder side; the master modport is the sequencer side.
interface rv32i_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Turns a symbolic RV32I descriptor into its 32-bit machine word, tagged with an
// incrementing word address; illegal descriptors are consumed and counted.
module rv32i_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  rv32i_instr_encoder_if.slave bus,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

  logic                 out_valid_reg;
  logic [31:0]          out_instr_reg;
  logic [31:0]          out_addr_reg;
  logic                 err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic        accept;
  logic        xfer;
  logic [31:0] enc_next;
  logic        legal_next;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic        sh_ok;
  logic        u_ok;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  // Flush blocks acceptance so a descriptor offered in that cycle is dropped.
  assign bus.in_ready = !flush && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_reg && bus.out_ready;

  assign i_ok  = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
  assign b_ok  = !imm[0] && ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094);
  assign j_ok  = !imm[0] && ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574);
  assign sh_ok = (imm[31:5] == 27'd0);
  assign u_ok  = (imm[31:20] == 12'd0);

  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    case (bus.in_op)
      6'd5, 6'd11, 6'd16, 6'd24, 6'd29: funct3 = 3'b001;
      6'd12, 6'd17, 6'd19, 6'd30:       funct3 = 3'b010;
      6'd20, 6'd31:                     funct3 = 3'b011;
      6'd6, 6'd13, 6'd21, 6'd32:        funct3 = 3'b100;
      6'd7, 6'd14, 6'd25, 6'd33:        funct3 = 3'b101;
      6'd26, 6'd34: begin
        funct3 = 3'b101;
        funct7 = 7'b0100000;
      end
      6'd8, 6'd22, 6'd35:               funct3 = 3'b110;
      6'd9, 6'd23, 6'd36:               funct3 = 3'b111;
      6'd28:                            funct7 = 7'b0100000;
      default: ;
    endcase
  end

  always_comb begin
    enc_next   = 32'd0;
    legal_next = 1'b1;
    case (bus.in_op) inside
      [6'd0:6'd1]: begin
        legal_next = u_ok;
        enc_next   = {imm[19:0], rd, (bus.in_op == 6'd0) ? 7'b0110111 : 7'b0010111};
      end
      6'd2: begin
        legal_next = j_ok;
        enc_next   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      6'd3: begin
        legal_next = i_ok;
        enc_next   = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      end
      [6'd4:6'd9]: begin
        legal_next = b_ok;
        enc_next   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      end
      [6'd10:6'd14]: begin
        legal_next = i_ok;
        enc_next   = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      end
      [6'd15:6'd17]: begin
        legal_next = i_ok;
        enc_next   = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      end
      [6'd18:6'd23]: begin
        legal_next = i_ok;
        enc_next   = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      end
      [6'd24:6'd26]: begin
        legal_next = sh_ok;
        enc_next   = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
      end
      [6'd27:6'd36]: enc_next = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      6'd37:         enc_next = 32'h0FF0000F;
      6'd38:         enc_next = 32'h00000073;
      6'd39:         enc_next = 32'h00100073;
      default:       legal_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'd0;
      out_addr_reg  <= BASE_ADDR;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_addr_reg  <= BASE_ADDR;
    end else begin
      // The address tracks the word being presented, so it advances on transfer.
      if (xfer) begin
        out_addr_reg <= out_addr_reg + 32'd4;
      end
      if (accept && legal_next) begin
        out_valid_reg <= 1'b1;
        out_instr_reg <= enc_next;
      end else if (xfer) begin
        out_valid_reg <= 1'b0;
      end
      if (accept && !legal_next) begin
        err_reg <= 1'b1;
        if (err_cnt_reg != '1) begin
          err_cnt_reg <= err_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_addr  = out_addr_reg;
  assign err           = err_reg;
  assign err_cnt       = err_cnt_reg;
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed test-plan vectors plus
// randomized descriptors checked against a field-arithmetic reference model.
module tb_rv32i_instr_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       err;
  logic [7:0] err_cnt;

  rv32i_instr_encoder_if bus ();

  rv32i_instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus.slave),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          prev_x = -10;
  int          last_x = -10;
  logic [31:0] model_addr = 32'h0;
  int          exp_cnt = 0;
  logic        exp_err = 1'b0;
  bit          bp_mode = 1'b0;
  bit          rdy_force = 1'b1;
  int          edges[22] = '{0, 1, 2, 3, 5, 8, -2, -1, 31, 32, 2047, 2048, -2048, -2049,
                             4094, 4095, 4096, -4096, -4098, 1048574, 1048576, -1048576};

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    bus.out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Output-side monitor: every transfer pops one expected word.
  always @(negedge clk) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h @ %h expected none", bus.out_instr, bus.out_addr);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] word %h @ %h (expect %h @ %h)", bus.out_instr, bus.out_addr, mon_e.instr, mon_e.addr);
        chk("word", bus.out_instr, mon_e.instr);
        chk("addr", bus.out_addr, mon_e.addr);
      end
      prev_x = last_x;
      last_x = cyc;
    end
  end

  function automatic longint fld(input longint s, input int lo, input int n);
    return (s >>> lo) & ((longint'(1) << n) - 1);
  endfunction

  // Reference: assemble the word from the ISA field tables with plain arithmetic.
  function automatic bit model_encode(input int op, input int rd, input int rs1, input int rs2,
                                      input logic [31:0] imm, output logic [31:0] w);
    int     br_f3[6]  = '{0, 1, 4, 5, 6, 7};
    int     ld_f3[5]  = '{0, 1, 2, 4, 5};
    int     ai_f3[6]  = '{0, 2, 3, 4, 6, 7};
    int     sh_f3[3]  = '{1, 5, 5};
    int     r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int     r_f7[10]  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    longint s;
    longint u;
    longint acc;
    bit     ok;
    s   = $signed(imm);
    u   = imm;
    ok  = 1'b1;
    acc = 0;
    if (op <= 1) begin
      ok  = (u < 1048576);
      acc = u * 4096 + rd * 128 + ((op == 0) ? 'h37 : 'h17);
    end else if (op == 2) begin
      ok  = (s % 2 == 0) && (s >= -1048576) && (s <= 1048574);
      acc = (fld(s, 20, 1) << 31) | (fld(s, 1, 10) << 21) | (fld(s, 11, 1) << 20)
          | (fld(s, 12, 8) << 12) | (rd << 7) | 'h6F;
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      ok  = (s >= -2048) && (s <= 2047);
      acc = (fld(s, 0, 12) << 20) | (rs1 << 15) | (rd << 7);
      if (op == 3) acc = acc | 'h67;
      else if (op <= 14) acc = acc | (ld_f3[op-10] << 12) | 'h03;
      else acc = acc | (ai_f3[op-18] << 12) | 'h13;
    end else if (op >= 4 && op <= 9) begin
      ok  = (s % 2 == 0) && (s >= -4096) && (s <= 4094);
      acc = (fld(s, 12, 1) << 31) | (fld(s, 5, 6) << 25) | (rs2 << 20) | (rs1 << 15)
          | (br_f3[op-4] << 12) | (fld(s, 1, 4) << 8) | (fld(s, 11, 1) << 7) | 'h63;
    end else if (op >= 15 && op <= 17) begin
      ok  = (s >= -2048) && (s <= 2047);
      acc = (fld(s, 5, 7) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 15) << 12)
          | (fld(s, 0, 5) << 7) | 'h23;
    end else if (op >= 24 && op <= 26) begin
      ok  = (s >= 0) && (s <= 31);
      acc = (((op == 26) ? 32 : 0) << 25) | (fld(s, 0, 5) << 20) | (rs1 << 15)
          | (sh_f3[op-24] << 12) | (rd << 7) | 'h13;
    end else if (op >= 27 && op <= 36) begin
      acc = (r_f7[op-27] << 25) | (rs2 << 20) | (rs1 << 15) | (r_f3[op-27] << 12)
          | (rd << 7) | 'h33;
    end else if (op == 37) acc = 'h0FF0000F;
    else if (op == 38) acc = 'h73;
    else if (op == 39) acc = 'h00100073;
    else ok = 1'b0;
    w = acc[31:0];
    return ok;
  endfunction

  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit use_const, input logic [31:0] const_w);
    logic [31:0] w;
    bit          legal;
    bit          rdy;
    int          n;
    legal        = model_encode(op, rd, rs1, rs2, imm, w);
    if (use_const) w = const_w;
    bus.in_valid = 1'b1;
    bus.in_op    = 6'(op);
    bus.in_rd    = 5'(rd);
    bus.in_rs1   = 5'(rs1);
    bus.in_rs2   = 5'(rs2);
    bus.in_imm   = imm;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for op %0d expected acceptance", op);
    end else if (legal) begin
      sb.push_back('{w, model_addr});
      model_addr = model_addr + 32'd4;
    end else begin
      exp_err = 1'b1;
      if (exp_cnt != 255) exp_cnt++;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_imm();
    int v;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: v = edges[$urandom_range(0, 21)];
      6:                v = int'($urandom);
      7:                v = int'($urandom_range(0, 32'hFFFFF));
      default:          v = int'($urandom_range(0, 200)) - 100;
    endcase
    return 32'(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_addr;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.in_imm   = '0;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI, then ADD/SUB back-to-back.
    send(18, 1, 0, 0, 32'd5, 1, 32'h00500093);
    send(27, 3, 1, 2, 32'd0, 1, 32'h002081B3);
    send(28, 3, 1, 2, 32'd0, 1, 32'h402081B3);
    idle();
    drain();
    chk("no_bubble", 32'(last_x - prev_x), 32'd1);

    send(4, 0, 1, 2, 32'd8, 1, 32'h00208463);
    send(0, 5, 0, 0, 32'h12345, 1, 32'h123452B7);
    send(38, 0, 0, 0, 32'd0, 1, 32'h00000073);
    idle();
    drain();

    // Three illegal descriptors: consumed, counted, no words.
    send(18, 1, 0, 0, 32'd2048, 0, 32'h0);
    send(4, 0, 1, 2, 32'd3, 0, 32'h0);
    send(45, 0, 0, 0, 32'd0, 0, 32'h0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_err_cnt", 32'(err_cnt), 32'd3);
    chk("illegal_out_valid", 32'(bus.out_valid), 32'd0);
    chk("illegal_out_addr", bus.out_addr, model_addr);

    // Backpressure: hold one word for 5 cycles with a second descriptor waiting.
    rdy_force = 1'b0;
    held_addr = model_addr;
    send(18, 1, 0, 0, 32'd5, 1, 32'h00500093);
    bus.in_valid = 1'b1;
    bus.in_op    = 6'd27;
    bus.in_rd    = 5'd3;
    bus.in_rs1   = 5'd1;
    bus.in_rs2   = 5'd2;
    bus.in_imm   = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_instr", bus.out_instr, 32'h00500093);
      chk("bp_out_addr", bus.out_addr, held_addr);
      @(posedge clk);
      #1;
    end
    rdy_force = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back('{32'h002081B3, model_addr});
    model_addr = model_addr + 32'd4;
    idle();
    drain();
    chk("bp_next_word_gap", 32'(last_x - prev_x), 32'd1);

    // Randomized descriptors under random output backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(int'($urandom_range(0, 47)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), pick_imm(), 0, 32'h0);
    end
    idle();
    bp_mode = 1'b0;
    drain();
    chk("rand_err", 32'(err), 32'(exp_err));
    chk("rand_err_cnt", 32'(err_cnt), 32'(exp_cnt));

    // Flush: a descriptor offered during flush is dropped; error state survives.
    chk("pre_flush_addr", bus.out_addr, model_addr);
    bus.in_valid = 1'b1;
    bus.in_op    = 6'd18;
    bus.in_imm   = 32'd7;
    flush        = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_addr", bus.out_addr, 32'd0);
    chk("flush_err", 32'(err), 32'(exp_err));
    chk("flush_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    model_addr = 32'h0;
    send(21, 4, 2, 0, 32'hFFFFF800, 0, 32'h0);
    idle();
    drain();

    // Asynchronous reset while a word is held.
    rdy_force = 1'b0;
    send(19, 6, 7, 0, 32'd100, 0, 32'h0);
    idle();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_instr", bus.out_instr, 32'd0);
    chk("arst_out_addr", bus.out_addr, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    sb.delete();
    model_addr = 32'h0;
    exp_cnt    = 0;
    exp_err    = 1'b0;
    rdy_force  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 9, 0, 0, 32'hABCDE, 0, 32'h0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
